// File: rtl/exec_ctrl.sv
// Execution sequencer for the 4-bit register CPU core.
// Turns two raw board buttons into run/halt and single-step control, then issues a
// one-clk step_en enable to the core: periodically in RUN, once per STEP.
// A single-address PC breakpoint stops RUN before the instruction at bp_addr executes.
// Button index 0 is run/halt and index 1 is single-step throughout this file.
module exec_ctrl #(
    parameter int   DIV_W     = 24,
    parameter int   DEB_W     = 16,
    parameter logic START_RUN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run_n,
    input  logic       btn_step_n,
    input  logic [3:0] pc,
    input  logic [3:0] bp_addr,
    input  logic       bp_en,
    output logic       step_en,
    output logic [1:0] state,
    output logic       halted,
    output logic       bp_hit
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    localparam logic [DEB_W-1:0] DEB_ZERO = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0] DEB_ONE  = {{(DEB_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

    // Button conditioning state (one element per button)
    logic [1:0]       btn_raw_s;
    logic [1:0]       sync1_r;
    logic [1:0]       sync2_r;
    logic [DEB_W-1:0] deb_cnt_r [2];
    logic [1:0]       level_r;     // debounced level, 1 = pressed
    logic [1:0]       press_r;     // one-clk press event
    logic [1:0]       changed_s;
    logic [1:0]       sat_s;
    logic [1:0]       pressed_s;

    // Sequencer state
    state_t           state_r;
    state_t           state_next_s;
    logic             step_en_r;
    logic             step_next_s;
    logic             skip_r;
    logic             skip_next_s;
    logic             halted_r;
    logic             bp_hit_r;
    logic [DIV_W-1:0] presc_r;
    logic             tick_s;
    logic             bp_match_s;
    logic             run_press_s;
    logic             step_press_s;

    assign btn_raw_s    = {btn_step_n, btn_raw_n_run()};
    assign run_press_s  = press_r[0];
    assign step_press_s = press_r[1];

    // Trivial wrapper keeps the button ordering explicit at the concatenation above
    function automatic logic btn_raw_n_run();
        return btn_run_n;
    endfunction

    // Derived per-button conditions: pending change, counter saturation, synced press level
    always_comb begin
        changed_s = 2'b00;
        sat_s     = 2'b00;
        pressed_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            changed_s[i] = sync1_r[i] ^ sync2_r[i];
            sat_s[i]     = &deb_cnt_r[i];
            pressed_s[i] = ~sync2_r[i];
        end
    end

    // Two-flop synchronizers; reset to the released (high) button level
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 2'b11;
            sync2_r <= 2'b11;
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counters: restart on any synced-level change, hold once saturated
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                deb_cnt_r[i] <= DEB_ZERO;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (changed_s[i]) begin
                    deb_cnt_r[i] <= DEB_ZERO;
                end else if (!sat_s[i]) begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DEB_ONE;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i];
                end
            end
        end
    end

    // Debounced level follows the synced level once stable; press fires on its 0->1 edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r <= 2'b00;
            press_r <= 2'b00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                press_r[i] <= sat_s[i] & pressed_s[i] & ~level_r[i];
                if (sat_s[i]) begin
                    level_r[i] <= pressed_s[i];
                end else begin
                    level_r[i] <= level_r[i];
                end
            end
        end
    end

    // Prescaler runs only in RUN and sits at zero elsewhere, so every RUN entry restarts it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_r <= DIV_ZERO;
        end else if (state_r == ST_RUN) begin
            presc_r <= presc_r + DIV_ONE;
        end else begin
            presc_r <= DIV_ZERO;
        end
    end

    assign tick_s     = (state_r == ST_RUN) && (&presc_r);
    assign bp_match_s = bp_en && (pc == bp_addr);

    // Next-state and next-output decode; run press outranks step press, which outranks tick
    always_comb begin
        state_next_s = state_r;
        step_next_s  = 1'b0;
        skip_next_s  = skip_r;
        case (state_r)
            ST_HALT: begin
                if (run_press_s) begin
                    state_next_s = ST_RUN;
                end else if (step_press_s) begin
                    state_next_s = ST_STEP;
                    step_next_s  = 1'b1;
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            ST_STEP: begin
                // The pulse is already out; any press arriving now is dropped
                state_next_s = ST_HALT;
            end
            ST_RUN: begin
                if (run_press_s) begin
                    state_next_s = ST_HALT;
                end else if (tick_s) begin
                    if (bp_match_s && !skip_r) begin
                        state_next_s = ST_BREAK;
                    end else begin
                        step_next_s = 1'b1;
                        skip_next_s = 1'b0;
                    end
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_BREAK: begin
                if (run_press_s) begin
                    // Let the instruction sitting at the breakpoint execute once
                    state_next_s = ST_RUN;
                    skip_next_s  = 1'b1;
                end else if (step_press_s) begin
                    state_next_s = ST_STEP;
                    step_next_s  = 1'b1;
                end else begin
                    state_next_s = ST_BREAK;
                end
            end
            default: begin
                state_next_s = ST_HALT;
            end
        endcase
    end

    // State, step enable, skip flag and status flags all registered together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= (START_RUN != 1'b0) ? ST_RUN : ST_HALT;
            step_en_r <= 1'b0;
            skip_r    <= 1'b0;
            halted_r  <= (START_RUN == 1'b0);
            bp_hit_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            step_en_r <= step_next_s;
            skip_r    <= skip_next_s;
            halted_r  <= (state_next_s != ST_RUN);
            bp_hit_r  <= (state_next_s == ST_BREAK);
        end
    end

    assign step_en = step_en_r;
    assign state   = state_r;
    assign halted  = halted_r;
    assign bp_hit  = bp_hit_r;

endmodule
